// File: rtl/hit_color_sequencer.sv
// Collision flash sequencer: each accepted hit shows the next colour from that side's
// palette for FLASH_FRAMES frames. Define HIT_COLOR_HOLD_EN to keep the last colour after a flash.
module hit_color_sequencer #(
  parameter int NUM_SIDES     = 4,
  parameter int PALETTE_DEPTH = 4,
  parameter int COLOR_W       = 4,
  parameter logic [0:NUM_SIDES-1][0:PALETTE_DEPTH-1][COLOR_W-1:0] PALETTE =
    64'hC446_8C62_8932_9113,
  parameter int FLASH_FRAMES  = 8,
  parameter logic [COLOR_W-1:0] IDLE_COLOR = '0,
  localparam int SW     = (NUM_SIDES > 1) ? $clog2(NUM_SIDES) : 1,
  localparam int STEP_W = (PALETTE_DEPTH > 1) ? $clog2(PALETTE_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               hit_valid,
  input  logic [SW-1:0]      hit_side,
  output logic [COLOR_W-1:0] color_out,
  output logic               flash_active,
  output logic [SW-1:0]      side_out,
  output logic [7:0]         frames_left
);

  // state | meaning
  // IDLE  | no flash running, color_out shows IDLE_COLOR (or held colour)
  // FLASH | flash running, frames_left counts frame ticks down to 0
  typedef enum logic {IDLE, FLASH} state_t;

  state_t               state_q, state_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [7:0]           frames_q, frames_d;
  logic [SW-1:0]        side_q, side_d;
  logic [STEP_W-1:0]    step_q [NUM_SIDES];
  logic [STEP_W-1:0]    step_d [NUM_SIDES];
  logic                 flash_q;
  logic                 hit_ok;

  // Sides beyond NUM_SIDES are dropped so they can never index past the tables.
  assign hit_ok = hit_valid && (int'(hit_side) < NUM_SIDES);

  always_comb begin
    state_d  = state_q;
    color_d  = color_q;
    frames_d = frames_q;
    side_d   = side_q;
    step_d   = step_q;
    if (hit_ok) begin
      color_d  = PALETTE[hit_side][step_q[hit_side]];
      step_d[hit_side] = (step_q[hit_side] == STEP_W'(PALETTE_DEPTH - 1)) ?
                         '0 : step_q[hit_side] + 1'b1;
      side_d   = hit_side;
      frames_d = 8'(FLASH_FRAMES);
      state_d  = FLASH;
    end else if (state_q == FLASH && frame_tick) begin
      frames_d = frames_q - 8'd1;
      if (frames_q == 8'd1) begin
        state_d = IDLE;
`ifdef HIT_COLOR_HOLD_EN
        color_d = color_q;
`else
        color_d = IDLE_COLOR;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      color_q  <= IDLE_COLOR;
      frames_q <= '0;
      side_q   <= '0;
      flash_q  <= 1'b0;
      for (int i = 0; i < NUM_SIDES; i++) step_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      color_q  <= color_d;
      frames_q <= frames_d;
      side_q   <= side_d;
      flash_q  <= (state_d == FLASH);
      for (int i = 0; i < NUM_SIDES; i++) step_q[i] <= step_d[i];
    end
  end

  assign color_out    = color_q;
  assign flash_active = flash_q;
  assign side_out     = side_q;
  assign frames_left  = frames_q;

endmodule
